// File: rtl/life_pkg.sv
// Shared life-game board constants and the seeder FSM state encoding.
package life_pkg;

    localparam int ROWS   = 32;
    localparam int COLS   = 32;
    localparam int DBITS  = 3;
    localparam int ROW_AW = 5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_FILL  = FILL,
        S_WRITE = WRITE,
        S_FIN   = FIN
    } state_t;

endpackage

// File: rtl/cell_sampler.sv
// Gathers DBITS LFSR bits LSB-first into one cell value and compares it
// against the latched density to decide whether the cell is alive.
module cell_sampler #(
    parameter int DBITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           rand_en,
    input  logic           rand_bit,
    input  logic [DBITS:0] dens_q,
    output logic           cell_valid,
    output logic           cell_alive
);

    localparam int CW = (DBITS > 1) ? $clog2(DBITS) : 1;

    logic [DBITS-1:0] acc_q;
    logic [DBITS-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(DBITS - 1));

    // acc_d already contains the bit drawn this cycle, so the final bit
    // takes part in the comparison on the same edge it is consumed.
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < DBITS; k++) begin
            if (cnt_q == CW'(k)) begin
                acc_d[k] = rand_bit;
            end
        end
    end

    assign cell_valid = rand_en && last_bit;
    assign cell_alive = ({1'b0, acc_d} < dens_q);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (rand_en) begin
            if (last_bit) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rand_board_seeder.sv
// Seeds the life board with a random generation: samples one cell per DBITS
// LFSR bits, packs a full row, then writes it with a held valid/ready request.
module rand_board_seeder #(
    parameter int ROWS   = life_pkg::ROWS,
    parameter int COLS   = life_pkg::COLS,
    parameter int DBITS  = life_pkg::DBITS,
    parameter int ROW_AW = life_pkg::ROW_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DBITS:0]    density,
    input  logic              rand_bit,
    output logic              rand_en,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ROW_AW-1:0] wr_addr,
    output logic [COLS-1:0]   wr_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    import life_pkg::*;

    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

    // Write handshake: wr_en rises in WRITE and stays high, with wr_addr and
    // wr_data frozen, until an edge where wr_en & wr_ready both hold.
    state_t            state_q;
    state_t            state_d;
    logic [DBITS:0]    dens_q;
    logic [ROW_AW-1:0] row_q;
    logic [CLW-1:0]    col_q;
    logic [COLS-1:0]   cells_q;
    logic              start_acc;
    logic              cell_valid;
    logic              cell_alive;
    logic              last_row;

    cell_sampler #(.DBITS(DBITS)) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_acc),
        .rand_en    (rand_en),
        .rand_bit   (rand_bit),
        .dens_q     (dens_q),
        .cell_valid (cell_valid),
        .cell_alive (cell_alive)
    );

    assign last_row = (row_q == ROW_AW'(ROWS - 1));

    always_comb begin
        state_d   = state_q;
        rand_en   = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                rand_en = 1'b1;
                busy    = 1'b1;
                if (cell_valid && col_q == CLW'(COLS - 1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (wr_ready) begin
                    state_d = last_row ? S_FIN : S_FILL;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dens_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cells_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                dens_q  <= density;
                row_q   <= '0;
                col_q   <= '0;
                cells_q <= '0;
            end
            if (cell_valid) begin
                cells_q[col_q] <= cell_alive;
                col_q          <= (col_q == CLW'(COLS - 1)) ? '0 : col_q + CLW'(1);
            end
            if (wr_en && wr_ready && !last_row) begin
                row_q <= row_q + ROW_AW'(1);
                col_q <= '0;
            end
        end
    end

    assign wr_addr = row_q;
    assign wr_data = cells_q;
    assign state   = state_q;

endmodule

// File: tb/tb_rand_board_seeder.sv
// Directed bench for rand_board_seeder on a 4x8 board with 3 bits per cell.
module tb_rand_board_seeder;

    import life_pkg::*;

    localparam int TROWS   = 4;
    localparam int TCOLS   = 8;
    localparam int TDBITS  = 3;
    localparam int TROW_AW = 2;
    localparam int W       = TROW_AW + TCOLS;
    localparam int NVEC    = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [TDBITS:0]    density;
    logic               rand_bit;
    logic               rand_en;
    logic               wr_en;
    logic               wr_ready;
    logic [TROW_AW-1:0] wr_addr;
    logic [TCOLS-1:0]   wr_data;
    logic               busy;
    logic               done;
    logic [1:0]         state;

    rand_board_seeder #(
        .ROWS(TROWS), .COLS(TCOLS), .DBITS(TDBITS), .ROW_AW(TROW_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .density  (density),
        .rand_bit (rand_bit),
        .rand_en  (rand_en),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LFSR stand-in: 0 random, 1 constant 0, 2 constant 1, 3 pattern 1,0,0,0,0,1
    int   mode_r    = 0;
    int   en_count  = 0;
    int   pat_base  = 0;
    logic rnd_bit   = 1'b0;

    always @(posedge clk) if (rand_en) en_count <= en_count + 1;
    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    always_comb begin
        int pos;
        pos      = (en_count - pat_base) % 6;
        rand_bit = 1'b0;
        case (mode_r)
            0: rand_bit = rnd_bit;
            1: rand_bit = 1'b0;
            2: rand_bit = 1'b1;
            3: rand_bit = (pos == 0 || pos == 5);
            default: rand_bit = 1'b0;
        endcase
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [TDBITS:0] dens;
        int              mode;
        logic [TCOLS-1:0] exp_row;
        int              stall_row;
        int              stall_len;
        bit              fin_start;
    } vec_t;

    vec_t vecs[NVEC];

    // driver: one complete seed, checking writes, latency and bit consumption
    task automatic run_seed(input vec_t v);
        int first_wr  = -1;
        int done_cyc  = -1;
        int stall_cnt = 0;
        int base;
        logic [W-1:0] exp_w;
        for (int r = 0; r < TROWS; r++) exp_q.push_back({TROW_AW'(r), v.exp_row});
        @(negedge clk);
        start    = 1'b1;
        density  = v.dens;
        mode_r   = v.mode;
        pat_base = en_count;
        base     = en_count;
        @(posedge clk);
        for (int cyc = 1; cyc <= 600 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) check("busy_at_start", {31'd0, busy}, 32'd1);
            check("rand_en_and_wr_en", {31'd0, rand_en & wr_en}, 32'd0);
            if (wr_en && first_wr < 0) first_wr = cyc;
            if (done) begin
                done_cyc = cyc;
                check("busy_in_fin", {31'd0, busy}, 32'd0);
                if (v.fin_start) start = 1'b1;
            end else if (wr_en) begin
                if (stall_cnt < v.stall_len && (stall_cnt > 0 || wr_addr == TROW_AW'(v.stall_row))) begin
                    wr_ready = 1'b0;
                    check("stall_addr", 32'(wr_addr), 32'(v.stall_row));
                    check("stall_data", 32'(wr_data), 32'(v.exp_row));
                    check("stall_rand_en", {31'd0, rand_en}, 32'd0);
                    if (stall_cnt == 2) start = 1'b1;
                    stall_cnt++;
                end else begin
                    wr_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_write: got addr %0d, no write expected", wr_addr);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("row_write", 32'({wr_addr, wr_data}), 32'(exp_w));
                    end
                end
            end else begin
                wr_ready = 1'($urandom_range(0, 1));
                check("busy_mid", {31'd0, busy}, 32'd1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        start    = 1'b0;
        wr_ready = 1'b1;
        check("first_wr_cycle", 32'(first_wr), 32'(1 + TCOLS * TDBITS));
        check("done_cycle", 32'(done_cyc), 32'(1 + TROWS * (TCOLS * TDBITS + 1) + v.stall_len));
        check("rand_en_cycles", 32'(en_count - base), 32'(TROWS * TCOLS * TDBITS));
        check("rows_outstanding", 32'(exp_q.size()), 32'd0);
        check("idle_after_done", {30'd0, state}, {30'd0, IDLE});
        check("busy_after_done", {31'd0, busy}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{dens: 4'd0,  mode: 0, exp_row: 8'h00, stall_row: 0, stall_len: 0, fin_start: 0};
        vecs[1] = '{dens: 4'd8,  mode: 0, exp_row: 8'hFF, stall_row: 0, stall_len: 0, fin_start: 1};
        vecs[2] = '{dens: 4'd1,  mode: 1, exp_row: 8'hFF, stall_row: 0, stall_len: 0, fin_start: 0};
        vecs[3] = '{dens: 4'd1,  mode: 2, exp_row: 8'h00, stall_row: 0, stall_len: 0, fin_start: 0};
        vecs[4] = '{dens: 4'd4,  mode: 3, exp_row: 8'h55, stall_row: 2, stall_len: 5, fin_start: 0};
        vecs[5] = '{dens: 4'd7,  mode: 2, exp_row: 8'h00, stall_row: 0, stall_len: 0, fin_start: 0};
        vecs[6] = '{dens: 4'd15, mode: 0, exp_row: 8'hFF, stall_row: 0, stall_len: 0, fin_start: 1};
        vecs[7] = '{dens: 4'd2,  mode: 3, exp_row: 8'h55, stall_row: 0, stall_len: 0, fin_start: 0};

        rst      = 1'b1;
        start    = 1'b0;
        density  = '0;
        wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {30'd0, state}, {30'd0, IDLE});
        check("rst_outputs", {28'd0, rand_en, wr_en, busy, done}, 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_seed(vecs[i]);

        // abort in FILL of row 1, then a clean restart
        @(negedge clk);
        start   = 1'b1;
        density = 4'd8;
        mode_r  = 0;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_in_fill", {30'd0, state}, {30'd0, FILL});
        check("abort_row", 32'(wr_addr), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {30'd0, state}, {30'd0, IDLE});
        check("abort_outputs", {28'd0, rand_en, wr_en, busy, done}, 32'd0);
        check("abort_wr_addr", 32'(wr_addr), 32'd0);
        check("abort_wr_data", 32'(wr_data), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("no_done_after_abort", {30'd0, busy, done}, 32'd0);
        end
        run_seed(vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
